// File: rtl/core_pkg.sv
// Shared core definitions: default widths, writeback request type, requester indices.
package core_pkg;

    localparam int unsigned DefDataWidth = 16;
    localparam int unsigned DefNumRegs   = 16;
    localparam int unsigned DefAddrWidth = $clog2(DefNumRegs);
    localparam int unsigned DefCntWidth  = 2;

    // Requester indices into the grant vector
    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_LSU = 1;

    typedef struct packed {
        logic [DefAddrWidth-1:0] addr;
        logic [DefDataWidth-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write counters with sticky error flag and RAW hazard lookup.
module regfile_scoreboard #(
    parameter int unsigned NumRegs   = 16,
    parameter int unsigned CntWidth  = 2,
    parameter int unsigned AddrWidth = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rsv_en,
    input  logic [AddrWidth-1:0] rsv_addr,
    input  logic                 dec_en,
    input  logic [AddrWidth-1:0] dec_addr,
    input  logic [AddrWidth-1:0] chk_addr1,
    input  logic [AddrWidth-1:0] chk_addr2,
    input  logic                 wr_en,
    input  logic [AddrWidth-1:0] wr_addr,
    output logic                 hazard,
    output logic                 sb_err
);

    localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};

    logic [CntWidth-1:0] cnt_q [NumRegs];
    logic [CntWidth-1:0] cnt_d [NumRegs];
    logic                err_q, err_d;

    // Next counts: reserve increments, accepted transfer decrements, both cancel out
    always_comb begin
        err_d = err_q;
        for (int unsigned i = 0; i < NumRegs; i++) begin
            logic inc, dec;
            cnt_d[i] = cnt_q[i];
            inc = rsv_en && (rsv_addr == AddrWidth'(i));
            dec = dec_en && (dec_addr == AddrWidth'(i));
            if (inc && !dec) begin
                if (cnt_q[i] == CntMax) err_d = 1'b1;
                else                    cnt_d[i] = cnt_q[i] + CntWidth'(1);
            end else if (dec && !inc) begin
                if (cnt_q[i] == '0) err_d = 1'b1;
                else                cnt_d[i] = cnt_q[i] - CntWidth'(1);
            end
        end
    end

    // Counter and sticky error state
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NumRegs; i++) cnt_q[i] <= '0;
            err_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NumRegs; i++) cnt_q[i] <= cnt_d[i];
            err_q <= err_d;
        end
    end

    // The in-flight registered write also counts: the register file is not yet updated
    always_comb begin
        hazard = (cnt_q[chk_addr1] != '0) || (cnt_q[chk_addr2] != '0)
              || (wr_en && ((wr_addr == chk_addr1) || (wr_addr == chk_addr2)));
    end

    assign sb_err = err_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load writeback.
module regfile_wb_arbiter
    import core_pkg::*;
#(
    parameter int unsigned DataWidth = DefDataWidth,
    parameter int unsigned NumRegs   = DefNumRegs,
    parameter int unsigned CntWidth  = DefCntWidth,
    localparam int unsigned AddrWidth = $clog2(NumRegs)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [AddrWidth-1:0] req0_addr,
    input  logic [DataWidth-1:0] req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [AddrWidth-1:0] req1_addr,
    input  logic [DataWidth-1:0] req1_data,
    output logic                 req1_ready,
    input  logic                 rsv_en,
    input  logic [AddrWidth-1:0] rsv_addr,
    input  logic [AddrWidth-1:0] chk_addr1,
    input  logic [AddrWidth-1:0] chk_addr2,
    output logic                 hazard,
    output logic                 reg_w_en,
    output logic [AddrWidth-1:0] addr_in,
    output logic [DataWidth-1:0] reg_in,
    output logic                 sb_err
);

    logic [1:0]           gnt;
    logic                 contended;
    logic                 xfer;
    logic                 rr_q, rr_d;  // 0: ALU preferred, 1: LSU preferred
    logic [AddrWidth-1:0] sel_addr;
    logic [DataWidth-1:0] sel_data;
    logic                 wen_q;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] data_q;

    // Grant and pointer update; the pointer only moves when both requesters compete
    always_comb begin
        gnt       = '0;
        contended = req0_valid && req1_valid;
        rr_d      = rr_q;
        if (!rst) begin
            if (contended) begin
                if (rr_q) gnt[REQ_LSU] = 1'b1;
                else      gnt[REQ_ALU] = 1'b1;
                rr_d = ~rr_q;
            end else begin
                gnt[REQ_ALU] = req0_valid;
                gnt[REQ_LSU] = req1_valid;
            end
        end
        xfer     = |gnt;
        sel_addr = gnt[REQ_LSU] ? req1_addr : req0_addr;
        sel_data = gnt[REQ_LSU] ? req1_data : req0_data;
    end

    assign req0_ready = gnt[REQ_ALU];
    assign req1_ready = gnt[REQ_LSU];

    // Round-robin pointer and registered write port; addr/data hold when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q   <= 1'b0;
            wen_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            rr_q  <= rr_d;
            wen_q <= xfer;
            if (xfer) begin
                addr_q <= sel_addr;
                data_q <= sel_data;
            end
        end
    end

    assign reg_w_en = wen_q;
    assign addr_in  = addr_q;
    assign reg_in   = data_q;

    regfile_scoreboard #(
        .NumRegs   (NumRegs),
        .CntWidth  (CntWidth),
        .AddrWidth (AddrWidth)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .dec_en    (xfer),
        .dec_addr  (sel_addr),
        .chk_addr1 (chk_addr1),
        .chk_addr2 (chk_addr2),
        .wr_en     (wen_q),
        .wr_addr   (addr_q),
        .hazard    (hazard),
        .sb_err    (sb_err)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_regfile_wb_arbiter;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0]  req0_addr, req1_addr, rsv_addr, chk_addr1, chk_addr2, addr_in;
    logic [15:0] req0_data, req1_data, reg_in;
    logic        rsv_en, hazard, reg_w_en, sb_err;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: plain integer counts, a preference bit, the expected write
    int      m_cnt [16];
    bit      m_err;
    bit      m_pref;  // 1 means the load unit wins the next tie
    bit      m_wen;
    wb_req_t m_w;

    always #5 clk = ~clk;

    regfile_wb_arbiter u_dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .chk_addr1  (chk_addr1),
        .chk_addr2  (chk_addr2),
        .hazard     (hazard),
        .reg_w_en   (reg_w_en),
        .addr_in    (addr_in),
        .reg_in     (reg_in),
        .sb_err     (sb_err)
    );

    // -1 none, 0 ALU, 1 load unit
    function automatic int model_winner();
        if (rst) return -1;
        if (req0_valid && req1_valid) return m_pref ? 1 : 0;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    function automatic bit model_hazard();
        return (m_cnt[chk_addr1] != 0) || (m_cnt[chk_addr2] != 0) ||
               (m_wen && (m_w.addr == chk_addr1 || m_w.addr == chk_addr2));
    endfunction

    task automatic model_clock();
        int w;
        w = model_winner();
        if (rst) begin
            foreach (m_cnt[r]) m_cnt[r] = 0;
            m_err = 0; m_pref = 0; m_wen = 0; m_w = '0;
            return;
        end
        for (int r = 0; r < 16; r++) begin
            int delta;
            delta = ((rsv_en && rsv_addr == r) ? 1 : 0)
                  - (((w == 0 && req0_addr == r) || (w == 1 && req1_addr == r)) ? 1 : 0);
            if (delta > 0) begin
                if (m_cnt[r] == 3) m_err = 1; else m_cnt[r]++;
            end else if (delta < 0) begin
                if (m_cnt[r] == 0) m_err = 1; else m_cnt[r]--;
            end
        end
        m_wen = (w >= 0);
        if (w == 0) m_w = '{addr: req0_addr, data: req0_data};
        if (w == 1) m_w = '{addr: req1_addr, data: req1_data};
        if (req0_valid && req1_valid) m_pref = !m_pref;
    endtask

    // Advance one clock; inputs change 1 time unit after the edge
    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; rsv_en = 0;
        req0_addr = 0; req1_addr = 0; req0_data = 0; req1_data = 0;
        rsv_addr = 0; chk_addr1 = 0; chk_addr2 = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        tick(); tick();
        req0_valid = 1; req1_valid = 1; #1;
        n_cmp++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
        end
        idle_inputs(); rst = 0;
        tick();
        n_cmp++;
        if (reg_w_en !== 1'b0 || sb_err !== 1'b0 || addr_in !== 4'd0 || reg_in !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: got wen=%b err=%b addr=%0h data=%0h want 0 0 0 0",
                     reg_w_en, sb_err, addr_in, reg_in);
        end
        for (int a = 0; a < 16; a++) begin
            chk_addr1 = 4'(a); chk_addr2 = 4'(15 - a); #1;
            n_cmp++;
            if (hazard !== 1'b0) begin
                n_fail++; $display("FAIL reset_hazard r%0d: got %b want 0", a, hazard);
            end
        end
    endtask

    task automatic test_single();
        rsv_en = 1; rsv_addr = 3; tick();
        rsv_en = 0;
        req0_valid = 1; req0_addr = 3; req0_data = 16'hBEEF; chk_addr1 = 3; #1;
        n_cmp++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL single_ready: got %b%b want 01", req1_ready, req0_ready);
        end
        tick();
        req0_valid = 0; #1;
        n_cmp++;
        if (reg_w_en !== 1'b1 || addr_in !== 4'd3 || reg_in !== 16'hBEEF || hazard !== 1'b1) begin
            n_fail++;
            $display("FAIL single_write: got wen=%b addr=%0h data=%0h hz=%b want 1 3 beef 1",
                     reg_w_en, addr_in, reg_in, hazard);
        end
        tick();
        n_cmp++;
        if (reg_w_en !== 1'b0 || hazard !== 1'b0 || addr_in !== 4'd3 || reg_in !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL single_after: got wen=%b hz=%b addr=%0h data=%0h want 0 0 3 beef",
                     reg_w_en, hazard, addr_in, reg_in);
        end
    endtask

    task automatic test_contention();
        wb_req_t alu [2];
        wb_req_t lsu [2];
        int seq [4] = '{0, 1, 0, 1};
        int ai = 0, li = 0;
        alu[0] = '{addr: 4'd8, data: 16'h1111}; alu[1] = '{addr: 4'd8, data: 16'h2222};
        lsu[0] = '{addr: 4'd9, data: 16'h3333}; lsu[1] = '{addr: 4'd9, data: 16'h4444};
        rsv_en = 1; rsv_addr = 8; tick(); tick();
        rsv_addr = 9; tick(); tick();
        rsv_en = 0;
        for (int c = 0; c < 4; c++) begin
            wb_req_t want;
            int g;
            req0_valid = (ai < 2); req1_valid = (li < 2);
            if (ai < 2) begin req0_addr = alu[ai].addr; req0_data = alu[ai].data; end
            if (li < 2) begin req1_addr = lsu[li].addr; req1_data = lsu[li].data; end
            #1;
            g = req1_ready ? 1 : 0;
            n_cmp++;
            if ((req0_ready ^ req1_ready) !== 1'b1 || g != seq[c]) begin
                n_fail++;
                $display("FAIL contention_grant c%0d: got r0=%b r1=%b want winner %0d",
                         c, req0_ready, req1_ready, seq[c]);
            end
            want = (seq[c] == 0) ? alu[ai < 2 ? ai : 1] : lsu[li < 2 ? li : 1];
            if (seq[c] == 0) ai++; else li++;
            tick();
            n_cmp++;
            if (reg_w_en !== 1'b1 || addr_in !== want.addr || reg_in !== want.data) begin
                n_fail++;
                $display("FAIL contention_write c%0d: got wen=%b addr=%0h data=%0h want 1 %0h %0h",
                         c, reg_w_en, addr_in, reg_in, want.addr, want.data);
            end
        end
        idle_inputs(); tick();
        chk_addr1 = 8; chk_addr2 = 9; #1;
        n_cmp++;
        if (hazard !== 1'b0 || sb_err !== 1'b0) begin
            n_fail++; $display("FAIL contention_clean: got hz=%b err=%b want 0 0", hazard, sb_err);
        end
    endtask

    task automatic test_hazard_window();
        bit want [5] = '{1, 1, 1, 1, 0};
        chk_addr1 = 5; chk_addr2 = 0;
        rsv_en = 1; rsv_addr = 5; tick();
        rsv_en = 0;
        for (int c = 0; c < 5; c++) begin
            req1_valid = (c == 2); req1_addr = 5; req1_data = 16'h5A5A; #1;
            n_cmp++;
            if (hazard !== want[c]) begin
                n_fail++; $display("FAIL hazard_window c%0d: got %b want %b", c, hazard, want[c]);
            end
            tick();
        end
        req1_valid = 0;
    endtask

    task automatic test_same_cycle();
        chk_addr1 = 7; chk_addr2 = 0;
        rsv_en = 1; rsv_addr = 7; tick();
        req0_valid = 1; req0_addr = 7; req0_data = 16'h0777; #1;
        n_cmp++;
        if (req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL same_ready: got %b want 1", req0_ready);
        end
        tick();
        idle_inputs(); chk_addr1 = 7; tick();
        n_cmp++;
        if (hazard !== 1'b1 || reg_w_en !== 1'b0 || sb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle: got hz=%b wen=%b err=%b want 1 0 0", hazard, reg_w_en, sb_err);
        end
        req0_valid = 1; req0_addr = 7; tick();
        req0_valid = 0; tick();
        n_cmp++;
        if (hazard !== 1'b0) begin
            n_fail++; $display("FAIL same_drain: got %b want 0", hazard);
        end
    endtask

    task automatic test_overflow();
        chk_addr1 = 2; chk_addr2 = 2;
        rsv_en = 1; rsv_addr = 2;
        tick(); tick(); tick();
        n_cmp++;
        if (sb_err !== 1'b0) begin
            n_fail++; $display("FAIL ovf_early: got %b want 0", sb_err);
        end
        tick();
        rsv_en = 0; #1;
        n_cmp++;
        if (sb_err !== 1'b1) begin
            n_fail++; $display("FAIL ovf_err: got %b want 1", sb_err);
        end
        // Saturated at 3: two writes leave it pending, the third clears it
        req0_valid = 1; req0_addr = 2; tick(); tick();
        req0_valid = 0; tick();
        n_cmp++;
        if (hazard !== 1'b1) begin
            n_fail++; $display("FAIL ovf_count2: got %b want 1", hazard);
        end
        req0_valid = 1; tick();
        req0_valid = 0; tick();
        n_cmp++;
        if (hazard !== 1'b0 || sb_err !== 1'b1) begin
            n_fail++; $display("FAIL ovf_count3: got hz=%b err=%b want 0 1", hazard, sb_err);
        end
        rst = 1; tick(); rst = 0;
        req1_valid = 1; req1_addr = 2; req1_data = 16'h2; tick();
        req1_valid = 0; #1;
        n_cmp++;
        if (sb_err !== 1'b1) begin
            n_fail++; $display("FAIL underflow_err: got %b want 1", sb_err);
        end
        rst = 1; tick(); rst = 0;
    endtask

    task automatic test_reset_midflight();
        rsv_en = 1; rsv_addr = 4; tick();
        rsv_addr = 6; tick();
        rsv_en = 0;
        req0_valid = 1; req0_addr = 4; req0_data = 16'hCAFE; tick();
        req0_valid = 0; rst = 1; #1;
        n_cmp++;
        if (reg_w_en !== 1'b1 || addr_in !== 4'd4) begin
            n_fail++; $display("FAIL midflight_pre: got wen=%b addr=%0h want 1 4", reg_w_en, addr_in);
        end
        tick();
        rst = 0; #1;
        n_cmp++;
        if (reg_w_en !== 1'b0 || addr_in !== 4'd0 || reg_in !== 16'd0 || sb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midflight_post: got wen=%b addr=%0h data=%0h err=%b want 0 0 0 0",
                     reg_w_en, addr_in, reg_in, sb_err);
        end
        for (int a = 0; a < 16; a++) begin
            chk_addr1 = 4'(a); chk_addr2 = 4'(a); #1;
            n_cmp++;
            if (hazard !== 1'b0) begin
                n_fail++; $display("FAIL midflight_cnt r%0d: got %b want 0", a, hazard);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            bit a0, a1;
            rst = ($urandom_range(0, 59) == 0);
            if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_valid = 1; req0_addr = 4'($urandom_range(0, 5));
                req0_data = 16'($urandom);
            end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1; req1_addr = 4'($urandom_range(0, 5));
                req1_data = 16'($urandom);
            end
            rsv_en = ($urandom_range(0, 1) == 1); rsv_addr = 4'($urandom_range(0, 5));
            chk_addr1 = 4'($urandom_range(0, 7)); chk_addr2 = 4'($urandom_range(0, 7));
            #1;
            n_cmp++;
            if (req0_ready !== (model_winner() == 0) || req1_ready !== (model_winner() == 1) ||
                hazard !== model_hazard() || reg_w_en !== m_wen || addr_in !== m_w.addr ||
                reg_in !== m_w.data || sb_err !== m_err) begin
                n_fail++;
                $display("FAIL random c%0d: got r=%b%b hz=%b wen=%b a=%0h d=%0h e=%b want r=%b%b hz=%b wen=%b a=%0h d=%0h e=%b",
                         c, req1_ready, req0_ready, hazard, reg_w_en, addr_in, reg_in, sb_err,
                         model_winner() == 1, model_winner() == 0, model_hazard(), m_wen,
                         m_w.addr, m_w.data, m_err);
            end
            a0 = req0_ready; a1 = req1_ready;
            tick();
            if (a0) req0_valid = 0;
            if (a1) req1_valid = 0;
        end
        idle_inputs(); rst = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_hazard_window();
        test_same_cycle();
        test_overflow();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
